// File: rtl/vend_pkg.sv
// vend_pkg: coin values, coin selector and FSM state encoding shared by the vending/change FSMs
// Contents: state_t (IDLE/DISPENSE/GAP/DONE), coin_t, coin value constants, coin_value(), is_mult5()
package vend_pkg;
    localparam int NICKEL_C  = 5;
    localparam int DIME_C    = 10;
    localparam int QUARTER_C = 25;
    localparam int GAP_W     = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_DISPENSE, ST_GAP, ST_DONE} state_t;
    typedef enum logic [1:0] {COIN_N, COIN_D, COIN_Q} coin_t;
    function automatic int coin_value(input coin_t c);
        return (c == COIN_Q) ? QUARTER_C : (c == COIN_D) ? DIME_C : NICKEL_C;
    endfunction
    function automatic logic is_mult5(input int unsigned a);
        return (a % 5) == 0;
    endfunction
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request/coin-eject bundle between a controller and the change dispenser
// Ports: Start/Amount/Ready (controller -> dispenser); Busy, QuarterOut, DimeOut, NickelOut,
//        Done, Error, CoinCount (dispenser -> controller)
interface change_dispenser_if #(parameter int AMT_W = 6);
    logic             Start;
    logic [AMT_W-1:0] Amount;
    logic             Ready;
    logic             Busy;
    logic             QuarterOut;
    logic             DimeOut;
    logic             NickelOut;
    logic             Done;
    logic             Error;
    logic [3:0]       CoinCount;
    modport master (output Start, Amount, Ready,
                    input  Busy, QuarterOut, DimeOut, NickelOut, Done, Error, CoinCount);
    modport slave  (input  Start, Amount, Ready,
                    output Busy, QuarterOut, DimeOut, NickelOut, Done, Error, CoinCount);
endinterface

// File: rtl/gap_timer.sv
// gap_timer: reloadable down-counter that flags the final cycle of an inter-coin gap
// Ports: i_clk, i_rst_n (async active-low), i_load (reload with GAP_CYCLES), o_expire (last gap cycle)
module gap_timer import vend_pkg::*; #(
    parameter int GAP_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_expire
);
    logic [GAP_W-1:0] r_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else if (i_load) r_cnt <= GAP_W'(GAP_CYCLES);
        else if (r_cnt != '0) r_cnt <= r_cnt - GAP_W'(1);
    end
    // Loaded on the coin edge, so a count of 1 marks the GAP_CYCLES-th gap cycle
    assign o_expire = (r_cnt == GAP_W'(1));
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy quarter/dime/nickel change dispenser with enforced inter-coin gap
// Ports: Clk, Reset (async active-low); bus (slave): Start/Amount/Ready in, Busy, coin pulses,
//        Done, Error, CoinCount out -- all outputs registered
module change_dispenser import vend_pkg::*; #(
    parameter int GAP_CYCLES = 2,
    parameter int AMT_W      = 6
) (
    input logic               Clk,
    input logic               Reset,
    change_dispenser_if.slave bus
);
    state_t           r_state;
    logic [AMT_W-1:0] r_rem;
    logic [3:0]       r_cnt;
    logic             r_busy, r_q, r_d, r_n, r_done, r_err;
    coin_t            w_coin;
    logic [AMT_W-1:0] w_coin_val;
    logic             w_load, w_expire;
    always_comb begin
        w_coin     = (r_rem >= AMT_W'(QUARTER_C)) ? COIN_Q : (r_rem >= AMT_W'(DIME_C)) ? COIN_D : COIN_N;
        w_coin_val = AMT_W'(coin_value(w_coin));
    end
    assign w_load = (r_state == ST_DISPENSE) && (r_rem != '0) && bus.Ready;
    gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
        .i_clk    (Clk),
        .i_rst_n  (Reset),
        .i_load   (w_load),
        .o_expire (w_expire)
    );
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_q     <= 1'b0;
            r_d     <= 1'b0;
            r_n     <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_q    <= 1'b0;
            r_d    <= 1'b0;
            r_n    <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.Start && is_mult5(32'(bus.Amount))) begin
                        r_rem   <= bus.Amount;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_DISPENSE;
                    end else if (bus.Start) begin
                        r_err <= 1'b1;
                    end
                end
                ST_DISPENSE: begin
                    if (r_rem == '0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (bus.Ready) begin
                        // Greedy choice never exceeds r_rem, so the subtraction cannot wrap
                        r_q     <= (w_coin == COIN_Q);
                        r_d     <= (w_coin == COIN_D);
                        r_n     <= (w_coin == COIN_N);
                        r_rem   <= r_rem - w_coin_val;
                        r_cnt   <= (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_expire && r_rem != '0) begin
                        r_state <= ST_DISPENSE;
                    end else if (w_expire) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign bus.Busy       = r_busy;
    assign bus.QuarterOut = r_q;
    assign bus.DimeOut    = r_d;
    assign bus.NickelOut  = r_n;
    assign bus.Done       = r_done;
    assign bus.Error      = r_err;
    assign bus.CoinCount  = r_cnt;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and randomized checks of change_dispenser against a greedy-change model
module tb_change_dispenser;
    localparam int G  = 2;
    localparam int AW = 6;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int vectors     = 0;
    int miscompares = 0;
    int obs_coins[$];
    int obs_edges[$];
    int obs_done_edge, obs_done_cnt, obs_err_cnt, obs_err_edge, obs_busy_cnt, obs_multi, obs_count;
    change_dispenser_if #(.AMT_W(AW)) bus();
    change_dispenser #(.GAP_CYCLES(G), .AMT_W(AW)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    function automatic int enc(input int q[$]);
        int e = 0;
        foreach (q[i]) e = e * 100 + q[i];
        return e;
    endfunction
    // Drives one Start and records 40 cycles of outputs; c counts edges after the Start edge
    task automatic run_txn(input int amt, input int stall, input int restart_at);
        int n;
        obs_coins.delete();
        obs_edges.delete();
        obs_done_edge = -1; obs_done_cnt = 0; obs_err_cnt = 0; obs_err_edge = -1;
        obs_busy_cnt = 0; obs_multi = 0; obs_count = -1;
        @(negedge clk);
        bus.Start  = 1'b1;
        bus.Amount = AW'(amt);
        bus.Ready  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n = int'(bus.QuarterOut) + int'(bus.DimeOut) + int'(bus.NickelOut);
            if (n > 1) obs_multi++;
            if (bus.QuarterOut) begin obs_coins.push_back(25); obs_edges.push_back(c); end
            if (bus.DimeOut)    begin obs_coins.push_back(10); obs_edges.push_back(c); end
            if (bus.NickelOut)  begin obs_coins.push_back(5);  obs_edges.push_back(c); end
            if (bus.Done)  begin obs_done_cnt++; obs_done_edge = c; end
            if (bus.Error) begin obs_err_cnt++;  obs_err_edge  = c; end
            if (bus.Busy) obs_busy_cnt++;
            obs_count  = int'(bus.CoinCount);
            bus.Ready  = (c + 1 > stall);
            bus.Start  = (c == restart_at);
            if (c == restart_at) bus.Amount = AW'(15);
        end
        bus.Start = 1'b0;
    endtask
    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({bus.Busy, bus.QuarterOut, bus.DimeOut, bus.NickelOut, bus.Done, bus.Error, bus.CoinCount} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 0", {bus.Busy, bus.QuarterOut, bus.DimeOut, bus.NickelOut, bus.Done, bus.Error, bus.CoinCount});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.Busy, bus.Done, bus.Error} !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_release_idle: got %b expected 000", {bus.Busy, bus.Done, bus.Error});
        end
    endtask
    task automatic test_45();
        run_txn(45, 0, -1);
        vectors++; if (enc(obs_coins) != 251010) begin miscompares++; $display("FAIL c45_coins: got %0d expected 251010", enc(obs_coins)); end
        vectors++; if (enc(obs_edges) != 10407)  begin miscompares++; $display("FAIL c45_edges: got %0d expected 10407", enc(obs_edges)); end
        vectors++; if (obs_done_edge != 9 || obs_done_cnt != 1) begin miscompares++; $display("FAIL c45_done: got edge %0d cnt %0d expected edge 9 cnt 1", obs_done_edge, obs_done_cnt); end
        vectors++; if (obs_count != 3) begin miscompares++; $display("FAIL c45_count: got %0d expected 3", obs_count); end
        vectors++; if (obs_busy_cnt != 10) begin miscompares++; $display("FAIL c45_busy: got %0d expected 10", obs_busy_cnt); end
    endtask
    task automatic test_small();
        run_txn(15, 0, -1);
        vectors++; if (enc(obs_coins) != 1005) begin miscompares++; $display("FAIL c15_coins: got %0d expected 1005", enc(obs_coins)); end
        vectors++; if (obs_done_edge != 6 || obs_count != 2) begin miscompares++; $display("FAIL c15_done_count: got edge %0d count %0d expected 6 2", obs_done_edge, obs_count); end
        run_txn(30, 0, -1);
        vectors++; if (enc(obs_coins) != 2505) begin miscompares++; $display("FAIL c30_coins: got %0d expected 2505", enc(obs_coins)); end
        vectors++; if (obs_done_edge != 6 || obs_count != 2) begin miscompares++; $display("FAIL c30_done_count: got edge %0d count %0d expected 6 2", obs_done_edge, obs_count); end
    endtask
    task automatic test_zero();
        run_txn(0, 0, -1);
        vectors++; if (obs_coins.size() != 0) begin miscompares++; $display("FAIL c0_coins: got %0d coins expected 0", obs_coins.size()); end
        vectors++; if (obs_done_edge != 1 || obs_done_cnt != 1) begin miscompares++; $display("FAIL c0_done: got edge %0d cnt %0d expected edge 1 cnt 1", obs_done_edge, obs_done_cnt); end
        vectors++; if (obs_busy_cnt != 2) begin miscompares++; $display("FAIL c0_busy: got %0d expected 2", obs_busy_cnt); end
    endtask
    task automatic test_error();
        run_txn(7, 0, -1);
        vectors++; if (obs_err_cnt != 1 || obs_err_edge != 0) begin miscompares++; $display("FAIL c7_error: got cnt %0d edge %0d expected cnt 1 edge 0", obs_err_cnt, obs_err_edge); end
        vectors++; if (obs_busy_cnt != 0 || obs_done_cnt != 0 || obs_coins.size() != 0) begin
            miscompares++; $display("FAIL c7_quiet: got busy %0d done %0d coins %0d expected 0 0 0", obs_busy_cnt, obs_done_cnt, obs_coins.size());
        end
    endtask
    task automatic test_stall();
        run_txn(20, 5, 3);
        vectors++; if (enc(obs_coins) != 1010) begin miscompares++; $display("FAIL stall_coins: got %0d expected 1010", enc(obs_coins)); end
        vectors++; if (enc(obs_edges) != 609)  begin miscompares++; $display("FAIL stall_edges: got %0d expected 609", enc(obs_edges)); end
        vectors++; if (obs_done_edge != 11 || obs_done_cnt != 1) begin miscompares++; $display("FAIL stall_done: got edge %0d cnt %0d expected edge 11 cnt 1", obs_done_edge, obs_done_cnt); end
        vectors++; if (obs_count != 2) begin miscompares++; $display("FAIL stall_count: got %0d expected 2", obs_count); end
    endtask
    task automatic test_reset_mid();
        int stray = 0;
        @(negedge clk);
        bus.Start = 1'b1; bus.Amount = AW'(45); bus.Ready = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        @(negedge clk);
        vectors++; if (bus.QuarterOut !== 1'b1) begin miscompares++; $display("FAIL rmid_first_coin: got %b expected 1", bus.QuarterOut); end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.Busy, bus.QuarterOut, bus.DimeOut, bus.NickelOut, bus.Done, bus.Error, bus.CoinCount} !== 10'd0) begin
            miscompares++;
            $display("FAIL rmid_async_clear: got %b expected 0", {bus.Busy, bus.QuarterOut, bus.DimeOut, bus.NickelOut, bus.Done, bus.Error, bus.CoinCount});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.Busy || bus.QuarterOut || bus.DimeOut || bus.NickelOut || bus.Done) stray++;
        end
        vectors++; if (stray != 0) begin miscompares++; $display("FAIL rmid_no_resume: got %0d active cycles expected 0", stray); end
    endtask
    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            int amt, s, q, d, nk;
            int ec[$];
            int ee[$];
            int exp_done;
            amt = $urandom_range(0, 63);
            if ($urandom_range(0, 2) != 0) amt = 5 * $urandom_range(0, 12);
            s = $urandom_range(0, 3);
            run_txn(amt, s, -1);
            if (amt % 5 != 0) begin
                vectors++;
                if (obs_err_cnt != 1 || obs_busy_cnt != 0 || obs_coins.size() != 0 || obs_done_cnt != 0) begin
                    miscompares++;
                    $display("FAIL rnd_bad_amt %0d: got err %0d busy %0d coins %0d done %0d expected 1 0 0 0", amt, obs_err_cnt, obs_busy_cnt, obs_coins.size(), obs_done_cnt);
                end
                continue;
            end
            q  = amt / 25;
            d  = (amt % 25) / 10;
            nk = (amt % 25 % 10) / 5;
            repeat (q)  ec.push_back(25);
            repeat (d)  ec.push_back(10);
            repeat (nk) ec.push_back(5);
            foreach (ec[i]) ee.push_back(s + 1 + (G + 1) * i);
            exp_done = (ec.size() == 0) ? 1 : s + (G + 1) * ec.size();
            vectors++; if (enc(obs_coins) != enc(ec)) begin miscompares++; $display("FAIL rnd_coins amt %0d: got %0d expected %0d", amt, enc(obs_coins), enc(ec)); end
            vectors++; if (enc(obs_edges) != enc(ee)) begin miscompares++; $display("FAIL rnd_edges amt %0d stall %0d: got %0d expected %0d", amt, s, enc(obs_edges), enc(ee)); end
            vectors++; if (obs_done_edge != exp_done || obs_done_cnt != 1) begin miscompares++; $display("FAIL rnd_done amt %0d: got edge %0d cnt %0d expected edge %0d cnt 1", amt, obs_done_edge, obs_done_cnt, exp_done); end
            vectors++; if (obs_count != ((ec.size() > 15) ? 15 : ec.size())) begin miscompares++; $display("FAIL rnd_count amt %0d: got %0d expected %0d", amt, obs_count, ec.size()); end
            vectors++; if (obs_busy_cnt != exp_done + 1 || obs_err_cnt != 0 || obs_multi != 0) begin
                miscompares++;
                $display("FAIL rnd_busy_err amt %0d: got busy %0d err %0d multi %0d expected %0d 0 0", amt, obs_busy_cnt, obs_err_cnt, obs_multi, exp_done + 1);
            end
        end
    endtask
    initial begin
        bus.Start  = 1'b0;
        bus.Amount = '0;
        bus.Ready  = 1'b0;
        test_reset();
        test_45();
        test_small();
        test_zero();
        test_error();
        test_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter GAP_CYCLES, default 2: idle cycles enforced after each coin pulse (range 1..15).
REQ-002 Parameter AMT_W, default 6: width of the change amount in cents.
REQ-003 Clk  input  1  single clock; all state changes on the posedge of Clk.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  one-cycle request to dispense Amount.
REQ-006 Amount  input  AMT_W  change owed in cents; sampled only when Start=1 in IDLE.
REQ-007 Ready  input  1  coin mechanism can accept a coin this cycle.
REQ-008 Busy  output  1  transaction in progress.
REQ-009 QuarterOut, DimeOut, NickelOut  output  1 each  one-cycle coin-eject pulses, at most one high per cycle.
REQ-010 Done  output  1  one-cycle pulse: transaction complete.
REQ-011 Error  output  1  one-cycle pulse: Amount rejected.
REQ-012 CoinCount  output  4  coins issued in the current or last transaction, saturating at 15.

Function
REQ-013 The FSM SHALL have states IDLE, DISPENSE, GAP and DONE; all outputs SHALL be registered.
REQ-014 IDLE: Start=1 with Amount a multiple of 5 SHALL load Remaining<=Amount, clear CoinCount and enter DISPENSE next cycle.
REQ-015 IDLE: Start=1 with Amount not a multiple of 5 SHALL pulse Error for one cycle, issue no coins and stay in IDLE.
REQ-016 DISPENSE with Remaining=0 SHALL go to DONE without issuing a coin (Amount=0 case).
REQ-017 DISPENSE with Ready=0 SHALL hold: no coin pulse, Remaining unchanged.
REQ-018 DISPENSE with Ready=1 SHALL select greedily (>=25 quarter, else >=10 dime, else nickel), pulse that output on the next cycle, subtract its value from Remaining, increment CoinCount and enter GAP.
REQ-019 GAP SHALL last exactly GAP_CYCLES cycles, then go to DISPENSE if Remaining>0, else DONE.
REQ-020 DONE SHALL assert Done for exactly one cycle, then return to IDLE.
REQ-021 Busy SHALL be 1 in DISPENSE, GAP and DONE, and 0 in IDLE.
REQ-022 Start while Busy=1 SHALL be ignored; Amount SHALL NOT be resampled mid-transaction.
REQ-023 Remaining SHALL be AMT_W bits wide and SHALL never underflow, because greedy selection guarantees the coin value is <= Remaining.
REQ-024 Consecutive coin pulses SHALL be separated by at least GAP_CYCLES low cycles.

Reset
REQ-025 Reset=0 SHALL immediately force IDLE, Remaining=0, CoinCount=0, and Busy, Done, Error and all coin outputs to 0, regardless of Clk.
REQ-026 Reset asserted mid-transaction SHALL abandon remaining change; no coin or Done pulse SHALL follow the release of reset.

Structure
REQ-027 Coin values (5/10/25) and the state encoding SHALL reside in a shared package vend_pkg, which the vending FSM also uses.
REQ-028 The GAP counter SHALL be a sub-module gap_timer (load, count-down, expire flag).

Verification
REQ-029 Start, Amount=45, Ready=1 -> QuarterOut, DimeOut, DimeOut, each pulse separated by 2 low cycles; then Done; CoinCount=3.
REQ-030 Amount=15 -> DimeOut then NickelOut; Done; CoinCount=2. Amount=30 -> QuarterOut then NickelOut.
REQ-031 Amount=0 -> no coin pulses; Done on the 2nd cycle after Start; Busy high for 2 cycles.
REQ-032 Amount=7 -> Error pulse for one cycle; Busy stays 0; no Done.
REQ-033 Amount=20 with Ready held low for 5 cycles -> no coin pulses while stalled; once Ready=1, DimeOut, DimeOut; a second Start during Busy is ignored.
REQ-034 Reset asserted after the first coin of a 45 transaction -> outputs 0 asynchronously; after release, IDLE with no further pulses.
